// File: rtl/program_loader.sv
// program_loader: framed byte-stream loader that writes instruction memory and releases the core on a good checksum
module program_loader #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter logic [7:0]  BASE_ADDR = 8'h00,
  parameter int unsigned TIMEOUT   = 1000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       imem_we,
  output logic [7:0] imem_addr,
  output logic [7:0] imem_wdata,
  output logic       core_hold,
  output logic       done,
  output logic       error,
  output logic [1:0] err_code,
  output logic [8:0] byte_count
);
  typedef enum logic [2:0] {IDLE, LEN, DATA, CHK, DONE, ERR} state_t;
  state_t state, state_nx;
  logic [8:0] remaining;
  logic [7:0] sum;
  logic [31:0] idle_cnt;
  logic xfer, is_sync, active, timed_out;
  assign xfer = in_valid & in_ready;
  assign is_sync = in_data == SYNC_BYTE;
  assign active = state inside {LEN, DATA, CHK};
  // a transfer in the expiry cycle wins over the timeout
  assign timed_out = (TIMEOUT != 0) && active && !xfer && (idle_cnt == TIMEOUT - 1);
  assign core_hold = state != DONE;
  assign done = state == DONE;
  assign error = state == ERR;
  always_comb begin
    state_nx = state;
    if (timed_out)
      state_nx = ERR;
    else if (xfer)
      case (state)
        LEN:     state_nx = DATA;
        DATA:    state_nx = remaining == 9'd1 ? CHK : DATA;
        CHK:     state_nx = 8'(sum + in_data) == 8'h00 ? DONE : ERR;
        default: state_nx = is_sync ? LEN : state;
      endcase
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      in_ready <= 1'b0;
      imem_we <= 1'b0;
      imem_addr <= '0;
      imem_wdata <= '0;
      err_code <= 2'b00;
      byte_count <= '0;
      remaining <= '0;
      sum <= '0;
      idle_cnt <= '0;
    end else begin
      state <= state_nx;
      in_ready <= 1'b1;
      imem_we <= 1'b0;
      idle_cnt <= (xfer || !active) ? '0 : idle_cnt + 1;
      err_code <= state_nx != ERR ? 2'b00 : state == ERR ? err_code : timed_out ? 2'b10 : 2'b01;
      if (xfer && state == LEN) begin
        remaining <= in_data == 8'h00 ? 9'd256 : {1'b0, in_data};
        sum <= '0;
        byte_count <= '0;
      end
      if (xfer && state == DATA) begin
        remaining <= remaining - 9'd1;
        sum <= sum + in_data;
        imem_we <= 1'b1;
        imem_addr <= BASE_ADDR + byte_count[7:0];
        imem_wdata <= in_data;
        byte_count <= byte_count + 9'd1;
      end
    end
  end
endmodule

// File: tb/tb_program_loader.sv
// tb_program_loader: directed checks of framing, checksum, address wrap, timeout and reset recovery
module tb_program_loader;
  logic clock = 0, reset = 1, in_valid = 0;
  logic [7:0] in_data = 0;
  logic in_ready, imem_we, core_hold, done, error;
  logic [7:0] imem_addr, imem_wdata;
  logic [1:0] err_code;
  logic [8:0] byte_count;
  logic in_ready2, imem_we2, core_hold2, done2, error2;
  logic [7:0] imem_addr2, imem_wdata2;
  logic [1:0] err_code2;
  logic [8:0] byte_count2;
  int tests = 0, fails = 0, cyc = 0;
  logic [7:0] fr[$];
  logic [7:0] q_a[$], q_d[$], q2_a[$], q2_d[$];
  int q_c[$];

  program_loader dut (.clock(clock), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .err_code(err_code), .byte_count(byte_count));

  program_loader #(.BASE_ADDR(8'hFE), .TIMEOUT(8)) dut2 (.clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready2), .imem_we(imem_we2),
    .imem_addr(imem_addr2), .imem_wdata(imem_wdata2), .core_hold(core_hold2), .done(done2),
    .error(error2), .err_code(err_code2), .byte_count(byte_count2));

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;
  always @(negedge clock) begin
    if (imem_we) begin q_a.push_back(imem_addr); q_d.push_back(imem_wdata); q_c.push_back(cyc); end
    if (imem_we2) begin q2_a.push_back(imem_addr2); q2_d.push_back(imem_wdata2); end
  end

  task automatic send_frame;
    for (int i = 0; i < fr.size(); i++) begin
      in_valid = 1; in_data = fr[i];
      @(posedge clock); #1;
    end
    in_valid = 0;
  endtask

  task automatic do_reset;
    reset = 1; in_valid = 0;
    repeat (2) @(posedge clock);
    #1 reset = 0;
    @(posedge clock); #1;
    q_a = {}; q_d = {}; q_c = {}; q2_a = {}; q2_d = {};
  endtask

  task automatic test_reset;
    reset = 1; in_valid = 0;
    repeat (2) @(posedge clock);
    #1;
    tests++; if ({in_ready, imem_we, imem_addr, imem_wdata} !== 18'h0) begin fails++; $display("FAIL reset_io got %h exp 0", {in_ready, imem_we, imem_addr, imem_wdata}); end
    tests++; if ({core_hold, done, error, err_code} !== 5'b10000) begin fails++; $display("FAIL reset_status got %b exp 10000", {core_hold, done, error, err_code}); end
    tests++; if (byte_count !== 9'd0) begin fails++; $display("FAIL reset_count got %0d exp 0", byte_count); end
    reset = 0;
    @(posedge clock); #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ready_after_reset got %b exp 1", in_ready); end
    q_a = {}; q_d = {}; q_c = {}; q2_a = {}; q2_d = {};
  endtask

  task automatic test_good_frame;
    logic [7:0] ed[3] = '{8'h11, 8'h22, 8'h33};
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A};
    send_frame();
    repeat (2) @(posedge clock); #1;
    tests++; if (q_a.size() !== 3) begin fails++; $display("FAIL good_nwrites got %0d exp 3", q_a.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (q_a[i] !== 8'(i) || q_d[i] !== ed[i]) begin fails++; $display("FAIL good_write%0d got %h@%h exp %h@%h", i, q_d[i], q_a[i], ed[i], 8'(i)); end
    end
    tests++; if (q_c[1] - q_c[0] !== 1 || q_c[2] - q_c[1] !== 1) begin fails++; $display("FAIL good_consecutive got cycles %0d %0d %0d", q_c[0], q_c[1], q_c[2]); end
    tests++; if ({done, error, core_hold, err_code} !== 5'b10000) begin fails++; $display("FAIL good_status got %b exp 10000", {done, error, core_hold, err_code}); end
    tests++; if (byte_count !== 9'd3) begin fails++; $display("FAIL good_count got %0d exp 3", byte_count); end
  endtask

  task automatic test_bad_checksum;
    q_a = {};
    fr = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9B};
    send_frame();
    repeat (2) @(posedge clock); #1;
    tests++; if (q_a.size() !== 3) begin fails++; $display("FAIL bad_nwrites got %0d exp 3", q_a.size()); end
    tests++; if ({done, error, core_hold, err_code} !== 5'b01101) begin fails++; $display("FAIL bad_status got %b exp 01101", {done, error, core_hold, err_code}); end
  endtask

  task automatic test_garbage;
    do_reset();
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h01, 8'h42, 8'hBE};
    send_frame();
    @(posedge clock); #1;
    tests++; if (q_a.size() !== 1 || q_a[0] !== 8'h00 || q_d[0] !== 8'h42) begin fails++; $display("FAIL garbage_write got n=%0d %h@%h exp 42@00", q_a.size(), q_d[0], q_a[0]); end
    tests++; if ({done, core_hold} !== 2'b10) begin fails++; $display("FAIL garbage_done got %b exp 10", {done, core_hold}); end
    fr = '{8'hA5};
    send_frame();
    tests++; if ({done, core_hold} !== 2'b01) begin fails++; $display("FAIL rehold got %b exp 01", {done, core_hold}); end
    fr = '{8'h01, 8'h07, 8'hF9};
    send_frame();
    tests++; if ({done, core_hold, byte_count} !== {2'b10, 9'd1}) begin fails++; $display("FAIL reload got %b/%0d exp 10/1", {done, core_hold}, byte_count); end
  endtask

  task automatic test_wrap;
    logic [7:0] ea[3] = '{8'hFE, 8'hFF, 8'h00};
    do_reset();
    fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hFA};
    send_frame();
    @(posedge clock); #1;
    tests++; if (q2_a.size() !== 3) begin fails++; $display("FAIL wrap_nwrites got %0d exp 3", q2_a.size()); end
    for (int i = 0; i < 3; i++) begin
      tests++; if (q2_a[i] !== ea[i] || q2_d[i] !== 8'(i + 1)) begin fails++; $display("FAIL wrap_write%0d got %h@%h exp %h@%h", i, q2_d[i], q2_a[i], 8'(i + 1), ea[i]); end
    end
    tests++; if (done2 !== 1'b1) begin fails++; $display("FAIL wrap_done got %b exp 1", done2); end
  endtask

  task automatic test_len256;
    do_reset();
    fr = '{8'hA5, 8'h00};
    for (int i = 0; i < 256; i++) fr.push_back(8'(i));
    fr.push_back(8'h80);
    send_frame();
    @(posedge clock); #1;
    tests++; if (q_a.size() !== 256) begin fails++; $display("FAIL len256_nwrites got %0d exp 256", q_a.size()); end
    tests++; if (q_a[255] !== 8'hFF || q_d[255] !== 8'hFF) begin fails++; $display("FAIL len256_last got %h@%h exp FF@FF", q_d[255], q_a[255]); end
    tests++; if (byte_count !== 9'd256 || done !== 1'b1) begin fails++; $display("FAIL len256_status got %0d/%b exp 256/1", byte_count, done); end
  endtask

  task automatic test_timeout;
    do_reset();
    fr = '{8'hA5, 8'h03, 8'h11};
    send_frame();
    repeat (7) @(posedge clock); #1;
    tests++; if (error2 !== 1'b0) begin fails++; $display("FAIL timeout_early got %b exp 0", error2); end
    @(posedge clock); #1;
    tests++; if ({error2, err_code2, core_hold2} !== 4'b1101) begin fails++; $display("FAIL timeout_err got %b exp 1101", {error2, err_code2, core_hold2}); end
    do_reset();
    fr = '{8'hA5, 8'h03, 8'h11};
    send_frame();
    repeat (7) @(posedge clock); #1;
    fr = '{8'h22};
    send_frame();
    tests++; if ({error2, err_code2} !== 3'b000) begin fails++; $display("FAIL timeout_avoid got %b exp 000", {error2, err_code2}); end
    fr = '{8'h33, 8'h9A};
    send_frame();
    tests++; if ({done2, byte_count2} !== {1'b1, 9'd3}) begin fails++; $display("FAIL timeout_finish got %b/%0d exp 1/3", done2, byte_count2); end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    fr = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_frame();
    reset = 1;
    repeat (3) @(posedge clock); #1;
    tests++; if (q_a.size() !== 2) begin fails++; $display("FAIL midreset_nwrites got %0d exp 2", q_a.size()); end
    tests++; if ({imem_we, in_ready, core_hold, done, error, err_code, byte_count} !== {5'b00100, 2'b00, 9'd0}) begin fails++; $display("FAIL midreset_outputs got %h", {imem_we, in_ready, core_hold, done, error, err_code, byte_count}); end
    reset = 0;
    @(posedge clock); #1;
    fr = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'hF5};
    send_frame();
    @(posedge clock); #1;
    tests++; if (q_a.size() !== 4 || q_a[2] !== 8'h00 || q_d[2] !== 8'h05 || q_a[3] !== 8'h01 || q_d[3] !== 8'h06) begin fails++; $display("FAIL midreset_reload got n=%0d %h@%h %h@%h", q_a.size(), q_d[2], q_a[2], q_d[3], q_a[3]); end
    tests++; if ({done, core_hold} !== 2'b10) begin fails++; $display("FAIL midreset_done got %b exp 10", {done, core_hold}); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_garbage();
    test_wrap();
    test_len256();
    test_timeout();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
